adc_capture: RTL and testbench

//  Upstream stage of the OFDM demodulation path. Paces MCP3002 conversions at the audio sampling rate.

---
 rtl/adc_capture.sv | 238 +++++++++++++++++++++++
 tb/tb_adc_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// ---------------------------------------------------------------------------
// adc_capture
//
// Upstream stage of the OFDM demodulation path. Paces MCP3002 conversions at
// the audio sample rate and writes one block of NUM_SAMPLES 10-bit samples
// into the single-port ADC BSRAM at addresses 0..NUM_SAMPLES-1. The
// downstream demodulator reads the buffer once finish is raised and
// acknowledges it with clear (same start/finish/clear handshake as the
// fft1024/ofdm stages).
//
// Optional feature (compile-time macro ADC_CAPTURE_TRIG_EN):
//   When defined, start enters an ARM state. Conversions are consumed at the
//   tick rate but not written until a fresh sample has |x-512| greater than
//   TRIG_THRESHOLD. That sample is written at address 0 and counts toward
//   NUM_SAMPLES. Overruns while armed are not counted. When undefined, the
//   capture begins at the first tick after start.
//
// Ports
//   clk                 in   1   system clock
//   rst                 in   1   synchronous active-high reset
//   start               in   1   1-cycle pulse, begins capture when idle
//   finish              out  1   buffer full, held until clear
//   clear               in   1   1-cycle pulse, acknowledges finish
//   busy                out  1   high from accepted start until clear
//   overrun_cnt         out  8   saturating count of ticks with no fresh sample
//   adc_enable          out  1   to mcp3002: run conversions
//   adc_data            in   10  from mcp3002: latest conversion
//   adc_available       in   1   from mcp3002: fresh conversion pending
//   adc_clear_available out  1   to mcp3002: 1-cycle ack of consumed sample
//   sp_oce/sp_ce/sp_wre out  1   ADC BSRAM controls
//   sp_ad               out  13  ADC BSRAM address
//   sp_din              out  10  ADC BSRAM write data
// ---------------------------------------------------------------------------
module adc_capture #(
  parameter int CLK_FREQ          = 48_000_000,
  parameter int ADC_SAMPLING_FREQ = 48_000,
  parameter int NUM_SAMPLES       = 8192,
  parameter int TRIG_THRESHOLD    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        finish,
  input  logic        clear,
  output logic        busy,
  output logic [7:0]  overrun_cnt,
  output logic        adc_enable,
  input  logic [9:0]  adc_data,
  input  logic        adc_available,
  output logic        adc_clear_available,
  output logic        sp_oce,
  output logic        sp_ce,
  output logic        sp_wre,
  output logic [12:0] sp_ad,
  output logic [9:0]  sp_din
);

  localparam int SAMPLE_CYCLE = CLK_FREQ / ADC_SAMPLING_FREQ;
  localparam int CNT_W        = (SAMPLE_CYCLE > 1) ? $clog2(SAMPLE_CYCLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_CYCLE - 1);
  // The index is one bit wider than the address so it can reach NUM_SAMPLES,
  // which marks "all samples written".
  localparam logic [13:0] IDX_END = 14'(NUM_SAMPLES);

`ifdef ADC_CAPTURE_TRIG_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [13:0]       idx_q, idx_d;
  logic [9:0]        sample_q, sample_d;
  logic [7:0]        overrun_q, overrun_d;
  logic              finish_q, finish_d;
  logic              busy_q, busy_d;
  logic              adc_en_q, adc_en_d;
  logic              clr_avail_q, clr_avail_d;
  logic              wr_q, wr_d;
  logic [12:0]       sp_ad_q, sp_ad_d;
  logic [9:0]        sp_din_q, sp_din_d;
  logic              tick;

`ifdef ADC_CAPTURE_TRIG_EN
  // Distance of a conversion from mid-scale, as an 11-bit magnitude.
  function automatic logic [10:0] mid_dist(input logic [9:0] x);
    logic signed [10:0] diff;
    diff = $signed({1'b0, x}) - 11'sd512;
    mid_dist = (diff < 0) ? 11'(-diff) : 11'(diff);
  endfunction

  logic trig_hit;
  assign trig_hit = (mid_dist(adc_data) > 11'(TRIG_THRESHOLD));
`endif

  assign tick = (cnt_q == CNT_LAST);

  // Next-state and datapath. Every tick consumes a fresh conversion if one is
  // pending; the write itself is registered so the BSRAM sees it on the cycle
  // after the tick, together with the ack to the converter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sample_d    = sample_q;
    overrun_d   = overrun_q;
    finish_d    = finish_q;
    busy_d      = busy_q;
    adc_en_d    = adc_en_q;
    clr_avail_d = 1'b0;
    wr_d        = 1'b0;
    sp_ad_d     = sp_ad_q;
    sp_din_d    = sp_din_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef ADC_CAPTURE_TRIG_EN
          state_d = S_ARM;
`else
          state_d = S_RUN;
`endif
          busy_d    = 1'b1;
          adc_en_d  = 1'b1;
          overrun_d = 8'd0;
          idx_d     = 14'd0;
          cnt_d     = '0;
        end
      end

`ifdef ADC_CAPTURE_TRIG_EN
      S_ARM: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        // Only a fresh conversion may trigger; the held sample is never
        // re-evaluated, so a stale (or reset) value cannot fire the trigger.
        if (tick && adc_available) begin
          sample_d    = adc_data;
          clr_avail_d = 1'b1;
          if (trig_hit) begin
            wr_d     = 1'b1;
            sp_ad_d  = 13'd0;
            sp_din_d = adc_data;
            idx_d    = 14'd1;
            state_d  = S_RUN;
          end
        end
      end
`endif

      S_RUN: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (idx_q == IDX_END) begin
          state_d  = S_DONE;
          finish_d = 1'b1;
          adc_en_d = 1'b0;
        end else if (tick) begin
          if (adc_available) begin
            sample_d    = adc_data;
            clr_avail_d = 1'b1;
          end else if (overrun_q != 8'hFF) begin
            overrun_d = overrun_q + 8'd1;
          end
          wr_d     = 1'b1;
          sp_ad_d  = idx_q[12:0];
          sp_din_d = adc_available ? adc_data : sample_q;
          idx_d    = idx_q + 14'd1;
        end
      end

      S_DONE: begin
        // clear wins over a simultaneous start; start is otherwise ignored.
        if (clear) begin
          state_d  = S_IDLE;
          finish_d = 1'b0;
          busy_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= 14'd0;
      sample_q    <= 10'd0;
      overrun_q   <= 8'd0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      adc_en_q    <= 1'b0;
      clr_avail_q <= 1'b0;
      wr_q        <= 1'b0;
      sp_ad_q     <= 13'd0;
      sp_din_q    <= 10'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sample_q    <= sample_d;
      overrun_q   <= overrun_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
      adc_en_q    <= adc_en_d;
      clr_avail_q <= clr_avail_d;
      wr_q        <= wr_d;
      sp_ad_q     <= sp_ad_d;
      sp_din_q    <= sp_din_d;
    end
  end

  assign finish              = finish_q;
  assign busy                = busy_q;
  assign overrun_cnt         = overrun_q;
  assign adc_enable          = adc_en_q;
  assign adc_clear_available = clr_avail_q;
  // The block only writes, so the output-register clock enable stays low.
  assign sp_oce              = 1'b0;
  assign sp_ce               = wr_q;
  assign sp_wre              = wr_q;
  assign sp_ad               = sp_ad_q;
  assign sp_din              = sp_din_q;

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with a 10-cycle sample period and a
// 16-sample block. A small converter model steps its data on every ack.
module tb_adc_capture;

  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        clear;
  logic        finish;
  logic        busy;
  logic [7:0]  overrun_cnt;
  logic        adc_enable;
  logic [9:0]  adc_data;
  logic        adc_available;
  logic        adc_clear_available;
  logic        sp_oce;
  logic        sp_ce;
  logic        sp_wre;
  logic [12:0] sp_ad;
  logic [9:0]  sp_din;

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc         = 0;
  int startCyc    = 0;
  int finishCyc   = 0;

  int wrCount  = 0;
  int clrCount = 0;
  int modelIdx = 0;
  bit useTable = 1'b0;
  int wrAddr[64];
  int wrData[64];
  int wrCyc[64];
  logic [9:0] seqTbl[32];

  adc_capture #(
    .CLK_FREQ(480),
    .ADC_SAMPLING_FREQ(48),
    .NUM_SAMPLES(NS),
    .TRIG_THRESHOLD(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .finish(finish),
    .clear(clear),
    .busy(busy),
    .overrun_cnt(overrun_cnt),
    .adc_enable(adc_enable),
    .adc_data(adc_data),
    .adc_available(adc_available),
    .adc_clear_available(adc_clear_available),
    .sp_oce(sp_oce),
    .sp_ce(sp_ce),
    .sp_wre(sp_wre),
    .sp_ad(sp_ad),
    .sp_din(sp_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Write monitor plus converter model: each ack advances the data.
  always @(negedge clk) begin
    if (sp_ce && sp_wre) begin
      if (wrCount < 64) begin
        wrAddr[wrCount] = int'(sp_ad);
        wrData[wrCount] = int'(sp_din);
        wrCyc[wrCount]  = cyc;
      end
      wrCount++;
    end
    if (adc_clear_available) begin
      clrCount++;
      if (modelIdx < 31) modelIdx++;
      adc_data = useTable ? seqTbl[modelIdx] : adc_data + 10'd1;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit doStart, input bit doClear);
    start = doStart;
    clear = doClear;
    stepCycles(1);
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic resetMonitor();
    wrCount  = 0;
    clrCount = 0;
    modelIdx = 0;
  endtask

  task automatic waitFinish(input int budget);
    int n = 0;
    while (!finish && n < budget) begin
      stepCycles(1);
      n++;
    end
    checkOutput("finish_reached", int'(finish), 1);
    finishCyc = cyc;
  endtask

  function automatic int expSkip(input int k);
    if (k < 3) return k;
    if (k < 5) return 2;
    return k - 2;
  endfunction

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    clear         = 1'b0;
    adc_available = 1'b1;
    adc_data      = 10'd0;
    seqTbl[0] = 10'd512;
    seqTbl[1] = 10'd540;
    seqTbl[2] = 10'd600;
    seqTbl[3] = 10'd577;
    for (int i = 4; i < 32; i++) seqTbl[i] = 10'(300 + i);

    // Reset state
    stepCycles(3);
    checkOutput("rst_finish", int'(finish), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_adc_enable", int'(adc_enable), 0);
    checkOutput("rst_sp_ce", int'(sp_ce), 0);
    checkOutput("rst_sp_ad", int'(sp_ad), 0);
    rst = 1'b0;
    stepCycles(2);

    // Test 1: ramp, every tick available
    $display("[TB] ramp capture");
    resetMonitor();
    adc_data = 10'd0;
    applyStimulus(1'b1, 1'b0);
    startCyc = cyc;
    checkOutput("t1_busy", int'(busy), 1);
    checkOutput("t1_adc_enable", int'(adc_enable), 1);
    waitFinish(400);
    checkOutput("t1_wr_count", wrCount, NS);
    for (int k = 0; k < NS; k++) begin
      checkOutput($sformatf("t1_addr%0d", k), wrAddr[k], k);
      checkOutput($sformatf("t1_data%0d", k), wrData[k], k);
    end
    checkOutput("t1_first_write_delay", wrCyc[0] - startCyc, 10);
    for (int k = 1; k < NS; k++)
      checkOutput($sformatf("t1_spacing%0d", k), wrCyc[k] - wrCyc[k-1], 10);
    checkOutput("t1_finish_after_last", finishCyc - wrCyc[NS-1], 1);
    checkOutput("t1_overrun", int'(overrun_cnt), 0);
    checkOutput("t1_clear_pulses", clrCount, NS);
    checkOutput("t1_adc_enable_done", int'(adc_enable), 0);
    checkOutput("t1_busy_done", int'(busy), 1);

    // Test 3: start ignored in DONE, then clear
    $display("[TB] handshake");
    applyStimulus(1'b1, 1'b0);
    stepCycles(15);
    checkOutput("t3_no_new_writes", wrCount, NS);
    checkOutput("t3_finish_held", int'(finish), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t3_finish_dropped", int'(finish), 0);
    checkOutput("t3_busy_dropped", int'(busy), 0);
    stepCycles(2);

    // Test 2: ticks 3 and 4 have no fresh conversion
    $display("[TB] overrun capture");
    resetMonitor();
    adc_data = 10'd0;
    adc_available = 1'b1;
    applyStimulus(1'b1, 1'b0);
    stepCycles(30);
    adc_available = 1'b0;
    stepCycles(20);
    adc_available = 1'b1;
    waitFinish(400);
    checkOutput("t2_wr_count", wrCount, NS);
    for (int k = 0; k < NS; k++) begin
      checkOutput($sformatf("t2_addr%0d", k), wrAddr[k], k);
      checkOutput($sformatf("t2_data%0d", k), wrData[k], expSkip(k));
    end
    checkOutput("t2_overrun", int'(overrun_cnt), 2);
    checkOutput("t2_clear_pulses", clrCount, 14);

    // Test 6: start and clear together in DONE
    $display("[TB] start with clear");
    applyStimulus(1'b1, 1'b1);
    checkOutput("t6_finish", int'(finish), 0);
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_adc_enable", int'(adc_enable), 0);
    resetMonitor();
    stepCycles(25);
    checkOutput("t6_no_capture", wrCount, 0);
    checkOutput("t6_still_idle", int'(busy), 0);

    // Test 4: reset during the write of index 7
    $display("[TB] reset mid-capture");
    resetMonitor();
    adc_data = 10'd0;
    applyStimulus(1'b1, 1'b0);
    stepCycles(80);
    checkOutput("t4_write_live", int'(sp_ce), 1);
    checkOutput("t4_write_addr", int'(sp_ad), 7);
    rst = 1'b1;
    stepCycles(1);
    checkOutput("t4_busy", int'(busy), 0);
    checkOutput("t4_adc_enable", int'(adc_enable), 0);
    checkOutput("t4_sp_ce", int'(sp_ce), 0);
    checkOutput("t4_sp_wre", int'(sp_wre), 0);
    checkOutput("t4_sp_ad", int'(sp_ad), 0);
    checkOutput("t4_sp_din", int'(sp_din), 0);
    checkOutput("t4_clear_avail", int'(adc_clear_available), 0);
    rst = 1'b0;
    stepCycles(1);
    resetMonitor();
    adc_data = 10'd100;
    applyStimulus(1'b1, 1'b0);
    stepCycles(11);
    checkOutput("t4_restart_count", wrCount, 1);
    checkOutput("t4_restart_addr", wrAddr[0], 0);
    checkOutput("t4_restart_data", wrData[0], 100);

`ifdef ADC_CAPTURE_TRIG_EN
    // Test 5: trigger on distance from mid-scale
    $display("[TB] trigger capture");
    rst = 1'b1;
    stepCycles(1);
    rst = 1'b0;
    stepCycles(1);
    useTable = 1'b1;
    resetMonitor();
    adc_data = seqTbl[0];
    applyStimulus(1'b1, 1'b0);
    waitFinish(600);
    checkOutput("t5_wr_count", wrCount, NS);
    checkOutput("t5_addr0", wrAddr[0], 0);
    checkOutput("t5_data0", wrData[0], 600);
    checkOutput("t5_addr1", wrAddr[1], 1);
    checkOutput("t5_data1", wrData[1], 577);
    useTable = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
